fifo_duth_mp: RTL and testbench

Multi-port circular FIFO, successor to the single-entry one-hot FIFO. Each cycle it accepts 0..PUSH_W entries and releases 0..POP_W entries. It exposes occupancy, free-slot count, an almost-full threshold, flush, and sticky-free error pulses. It sits between the vector issue/decode stage and the lane dispatch, where several micro-ops are produced or consumed per cycle.

---
 rtl/fifo_duth_mp.sv | 90 +++++++++
 tb/tb_fifo_duth_mp.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/fifo_duth_mp.sv
// fifo_duth_mp: multi-port circular FIFO accepting 0..PUSH_W and releasing 0..POP_W entries per cycle.
// Illegal requests are dropped whole and flagged by one-cycle registered error pulses.
module fifo_duth_mp #(
   parameter int DW = 16,
   parameter int DEPTH = 8,
   parameter int PUSH_W = 2,
   parameter int POP_W = 2,
   parameter int AF_LVL = DEPTH - 2,
   localparam int CW = $clog2(DEPTH + 1),
   localparam int PNW = $clog2(PUSH_W + 1),
   localparam int QNW = $clog2(POP_W + 1),
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic [PUSH_W*DW-1:0]   push_data,
   input  logic [PNW-1:0]         push_num,
   output logic [CW-1:0]          free_slots,
   output logic [POP_W*DW-1:0]    pop_data,
   output logic [POP_W-1:0]       pop_valid,
   input  logic [QNW-1:0]         pop_num,
   output logic [CW-1:0]          count,
   output logic                   empty,
   output logic                   almost_full,
   output logic                   push_err,
   output logic                   pop_err
);
   typedef logic [CW:0] sum_t;
   logic [DW-1:0] mem_q [DEPTH];
   logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic push_err_q, push_err_d, pop_err_q, pop_err_d;
   sum_t pn, qn, cnt_x, free_x;
   logic push_bad, pop_bad;

   // Pointer plus offset is always below 2*DEPTH, so one conditional subtract is a full modulo.
   function automatic logic [PW-1:0] wrap(input sum_t s);
      return PW'(s >= sum_t'(DEPTH) ? s - sum_t'(DEPTH) : s);
   endfunction

   assign pn = sum_t'(push_num);
   assign qn = sum_t'(pop_num);
   assign cnt_x = sum_t'(cnt_q);
   assign free_x = sum_t'(DEPTH) - cnt_x;
   assign push_bad = pn > free_x;
   assign pop_bad = qn > cnt_x;

   always_comb begin
      wr_d = flush ? '0 : push_bad ? wr_q : wrap(sum_t'(wr_q) + pn);
      rd_d = flush ? '0 : pop_bad ? rd_q : wrap(sum_t'(rd_q) + qn);
      cnt_d = flush ? '0 : CW'(cnt_x + (push_bad ? sum_t'(0) : pn) - (pop_bad ? sum_t'(0) : qn));
      push_err_d = !flush && push_bad;
      pop_err_d = !flush && pop_bad;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q <= '0;
         rd_q <= '0;
         cnt_q <= '0;
         push_err_q <= 1'b0;
         pop_err_q <= 1'b0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
         cnt_q <= cnt_d;
         push_err_q <= push_err_d;
         pop_err_q <= pop_err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && !flush && !push_bad)
         for (int k = 0; k < PUSH_W; k++)
            if (sum_t'(k) < pn) mem_q[wrap(sum_t'(wr_q) + sum_t'(k))] <= push_data[k*DW +: DW];
   end

   for (genvar j = 0; j < POP_W; j++) begin : g_pop
      assign pop_data[j*DW +: DW] = mem_q[wrap(sum_t'(rd_q) + sum_t'(j))];
      assign pop_valid[j] = sum_t'(j) < cnt_x;
   end

   assign count = cnt_q;
   assign free_slots = CW'(free_x);
   assign empty = cnt_q == '0;
   assign almost_full = cnt_x >= sum_t'(AF_LVL);
   assign push_err = push_err_q;
   assign pop_err = pop_err_q;
endmodule

// File: tb/tb_fifo_duth_mp.sv
// tb_fifo_duth_mp: drives one shared stimulus stream into an 8-deep and a 5-deep FIFO
// and checks both against queue-based reference models through an expectation scoreboard.
module tb_fifo_duth_mp;
   logic clk = 1'b0;
   logic rst, flush;
   logic [31:0] push_data;
   logic [1:0] push_num, pop_num;
   logic [3:0] c8, f8;
   logic [2:0] c5, f5;
   logic [31:0] pd8, pd5;
   logic [1:0] pv8, pv5;
   logic e8, e5, af8, af5, pe8, pe5, qe8, qe5;
   int total = 0, bad = 0;
   int dep [2] = '{8, 5};

   typedef struct packed {
      logic [4:0] cnt;
      logic pe;
      logic qe;
      logic [31:0] d;
   } exp_t;

   exp_t exq [2][$];
   logic [15:0] mq [2][$];

   always #5 clk = ~clk;

   fifo_duth_mp #(.DW(16), .DEPTH(8), .PUSH_W(2), .POP_W(2)) dut8 (
      .clk(clk), .rst(rst), .flush(flush), .push_data(push_data), .push_num(push_num),
      .free_slots(f8), .pop_data(pd8), .pop_valid(pv8), .pop_num(pop_num), .count(c8),
      .empty(e8), .almost_full(af8), .push_err(pe8), .pop_err(qe8));

   fifo_duth_mp #(.DW(16), .DEPTH(5), .PUSH_W(2), .POP_W(2)) dut5 (
      .clk(clk), .rst(rst), .flush(flush), .push_data(push_data), .push_num(push_num),
      .free_slots(f5), .pop_data(pd5), .pop_valid(pv5), .pop_num(pop_num), .count(c5),
      .empty(e5), .almost_full(af5), .push_err(pe5), .pop_err(qe5));

   task automatic chk(input string nm, input int i, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s depth%0d: got %0d expected %0d", nm, dep[i], act, exp);
      end
   endtask

   // Reference: occupancy is the queue length, the queue front is the oldest entry.
   task automatic model(input int i, input bit r, input bit f, input int pn, input int qn,
                        input logic [31:0] pd);
      exp_t e;
      bit pb, qb;
      pb = 1'b0;
      qb = 1'b0;
      if (r || f) mq[i].delete();
      else begin
         pb = pn > dep[i] - mq[i].size();
         qb = qn > mq[i].size();
         if (!qb) repeat (qn) void'(mq[i].pop_front());
         if (!pb) for (int k = 0; k < pn; k++) mq[i].push_back(pd[16*k +: 16]);
      end
      e.cnt = 5'(mq[i].size());
      e.pe = pb;
      e.qe = qb;
      e.d = '0;
      for (int j = 0; j < 2 && j < mq[i].size(); j++) e.d[16*j +: 16] = mq[i][j];
      exq[i].push_back(e);
   endtask

   task automatic cyc(input bit r, input bit f, input int pn, input int qn);
      @(negedge clk);
      rst = r;
      flush = f;
      push_num = 2'(pn);
      pop_num = 2'(qn);
      push_data = 32'($urandom);
      model(0, r, f, pn, qn, push_data);
      model(1, r, f, pn, qn, push_data);
   endtask

   initial begin
      exp_t e;
      int cnt, fs, nv;
      logic [31:0] pd;
      logic [1:0] pv;
      logic em, af, pe, qe;
      forever begin
         @(posedge clk);
         #1;
         for (int i = 0; i < 2; i++) begin
            if (exq[i].size() != 0) begin
               e = exq[i].pop_front();
               cnt = i ? int'(c5) : int'(c8);
               fs = i ? int'(f5) : int'(f8);
               pd = i ? pd5 : pd8;
               pv = i ? pv5 : pv8;
               em = i ? e5 : e8;
               af = i ? af5 : af8;
               pe = i ? pe5 : pe8;
               qe = i ? qe5 : qe8;
               nv = (int'(e.cnt) < 2) ? int'(e.cnt) : 2;
               chk("count", i, cnt, int'(e.cnt));
               chk("free_slots", i, fs, dep[i] - int'(e.cnt));
               chk("empty", i, int'(em), int'(e.cnt == 0));
               chk("almost_full", i, int'(af), int'(int'(e.cnt) >= dep[i] - 2));
               chk("pop_valid", i, int'(pv), (1 << nv) - 1);
               chk("push_err", i, int'(pe), int'(e.pe));
               chk("pop_err", i, int'(qe), int'(e.qe));
               for (int j = 0; j < nv; j++)
                  chk("pop_data", i, int'(pd[16*j +: 16]), int'(e.d[16*j +: 16]));
            end
         end
      end
   end

   initial begin
      rst = 1'b1;
      flush = 1'b0;
      push_num = '0;
      pop_num = '0;
      push_data = '0;
      cyc(1, 0, 0, 0);
      cyc(0, 0, 2, 0);
      repeat (3) cyc(0, 0, 2, 0);
      cyc(0, 0, 1, 0);
      cyc(0, 0, 0, 0);
      cyc(0, 1, 0, 0);
      cyc(0, 0, 0, 1);
      cyc(0, 0, 1, 1);
      cyc(0, 1, 0, 0);
      cyc(0, 0, 2, 0);
      cyc(0, 0, 2, 0);
      cyc(0, 0, 0, 2);
      cyc(0, 0, 0, 2);
      cyc(0, 0, 2, 0);
      cyc(0, 0, 0, 0);
      cyc(0, 1, 0, 0);
      cyc(0, 0, 2, 0);
      cyc(0, 0, 2, 0);
      repeat (20) cyc(0, 0, 2, 2);
      cyc(0, 0, 1, 0);
      cyc(0, 1, 2, 0);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 2, 0);
      cyc(0, 0, 2, 1);
      cyc(1, 0, 2, 0);
      cyc(0, 0, 0, 0);
      repeat (600)
         cyc($urandom_range(0, 99) == 0, $urandom_range(0, 29) == 0,
             $urandom_range(0, 2), $urandom_range(0, 2));
      cyc(0, 0, 0, 0);
      for (int n = 0; n < 10 && (exq[0].size() != 0 || exq[1].size() != 0); n++) @(posedge clk);
      #2;
      if (exq[0].size() != 0 || exq[1].size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain: pending=%0d expected 0", exq[0].size() + exq[1].size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
